// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and constants for the Block_RAM port arbiter
//
// Contents:
//   arb_state_t   : arbiter FSM state encoding (IDLE, OWN0, OWN1)
//   PORT0/PORT1   : port index constants, also used as the "last winner" value
//   CNT_W         : beat counter width for the default BURST_MAX of 4
//   arb_cnt_w()   : beat counter width for any BURST_MAX (never narrower than 1 bit)
package bram_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN0 = 2'd1,
        ARB_OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int BURST_MAX_DFLT = 4;
    localparam int CNT_W          = $clog2(BURST_MAX_DFLT);

    // BURST_MAX=1 would give a zero-width counter; keep one bit so the
    // comparison against BURST_MAX-1 (=0) still folds to "never extend".
    function automatic int arb_cnt_w(input int burst_max);
        return (burst_max > 1) ? $clog2(burst_max) : 1;
    endfunction

endpackage

// File: rtl/bram_arb_pick.sv
// rtl/bram_arb_pick.sv - combinational 2-way winner select for the BRAM arbiter
//
// Build option: BRAM_ARB_RR_EN
//   defined   : round-robin, on contention the port that did not win last goes
//   undefined : fixed priority, port 0 always wins contention; last is ignored
//
// Ports:
//   req0, req1 : in  - pending beat requests
//   last       : in  - port index of the most recent owner to release
//   win        : out - winning port index (only meaningful when req0|req1)
module bram_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic win
);

`ifdef BRAM_ARB_RR_EN
    always_comb begin
        win = (req0 & req1) ? ~last : req1;
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        win = ~req0 & req1;
    end
`endif

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter in front of a simple dual-port Block_RAM
//
// Port 0 is the AHB-lite RAM interface (CPU), port 1 a secondary master (DMA /
// frame fetch). Each granted beat is forwarded to the BRAM in the same cycle;
// reads return one cycle later with a registered rvalid pulse.
//
// Build option: BRAM_ARB_RR_EN (round-robin on contention, else fixed port-0 priority)
//
// Ports:
//   clk, RSTn                 : clock, asynchronous active-low reset
//   req*, lock*, we*          : beat request (held until gnt), keep ownership, write/read
//   addr*, be*, wdata*        : word address, byte enables, write data
//   gnt*                      : beat accepted this cycle (combinational)
//   rvalid*, rdata*           : read return, one cycle after a granted read
//   bram_addra/dina/wea       : BRAM write port
//   bram_addrb/doutb          : BRAM read port (1-cycle latency)
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [3:0]        be0,
    input  logic [3:0]        be1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic [3:0]        bram_wea,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb
);

    localparam int            CW       = arb_cnt_w(BURST_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          last, last_nxt;
    logic          pick_win;
    logic          gnt0_c, gnt1_c;

    logic              g_any;
    logic              g_port;
    logic              g_lock;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [3:0]        g_be;
    logic [DATA_W-1:0] g_wdata;
    logic              wr_fire, rd_fire;

    logic [ADDR_W-1:0] addra_q, addrb_q;
    logic [DATA_W-1:0] dina_q;

    bram_arb_pick u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (last),
        .win  (pick_win)
    );

    // Grants are masked while reset is held so an asynchronous reset in the
    // middle of a beat never lets a write strobe reach the BRAM.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (req0 | req1) begin
                    gnt0_c = ~pick_win;
                    gnt1_c = pick_win;
                end
            end
            ARB_OWN0: gnt0_c = req0;
            ARB_OWN1: gnt1_c = req1;
            default: ;
        endcase
    end

    assign gnt0 = gnt0_c & RSTn;
    assign gnt1 = gnt1_c & RSTn;

    assign g_any   = gnt0 | gnt1;
    assign g_port  = gnt1;
    assign g_lock  = g_port ? lock1  : lock0;
    assign g_we    = g_port ? we1    : we0;
    assign g_addr  = g_port ? addr1  : addr0;
    assign g_be    = g_port ? be1    : be0;
    assign g_wdata = g_port ? wdata1 : wdata0;
    assign wr_fire = g_any & g_we;
    assign rd_fire = g_any & ~g_we;

    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        last_nxt     = last;
        if (g_any) begin
            // beat_cnt counts beats already held under lock; once it reaches
            // BURST_MAX-1 the current beat is the last one this owner gets.
            if (g_lock && (beat_cnt < CNT_LAST)) begin
                state_nxt    = g_port ? ARB_OWN1 : ARB_OWN0;
                beat_cnt_nxt = beat_cnt + 1'b1;
            end else begin
                state_nxt    = ARB_IDLE;
                beat_cnt_nxt = '0;
                last_nxt     = g_port;
            end
        end else if ((state == ARB_OWN0) && !req0 && !lock0) begin
            // Owner walked away from its burst; it still counts as the last
            // winner so round-robin favours the other port next.
            state_nxt    = ARB_IDLE;
            beat_cnt_nxt = '0;
            last_nxt     = PORT0;
        end else if ((state == ARB_OWN1) && !req1 && !lock1) begin
            state_nxt    = ARB_IDLE;
            beat_cnt_nxt = '0;
            last_nxt     = PORT1;
        end else if ((state != ARB_IDLE) && (state != ARB_OWN0) && (state != ARB_OWN1)) begin
            state_nxt    = ARB_IDLE;
            beat_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state    <= ARB_IDLE;
            beat_cnt <= '0;
            last     <= PORT1;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            addra_q  <= '0;
            addrb_q  <= '0;
            dina_q   <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            last     <= last_nxt;
            rvalid0  <= gnt0 & ~we0;
            rvalid1  <= gnt1 & ~we1;
            if (wr_fire) begin
                addra_q <= g_addr;
                dina_q  <= g_wdata;
            end
            if (rd_fire) begin
                addrb_q <= g_addr;
            end
        end
    end

    // Granted beat goes straight to the BRAM; otherwise the address/data
    // lines keep the last granted value to avoid needless toggling.
    assign bram_wea   = wr_fire ? g_be    : 4'b0000;
    assign bram_addra = wr_fire ? g_addr  : addra_q;
    assign bram_dina  = wr_fire ? g_wdata : dina_q;
    assign bram_addrb = rd_fire ? g_addr  : addrb_q;

    assign rdata0 = bram_doutb;
    assign rdata1 = bram_doutb;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 32;
    localparam int BURST_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              RSTn;
    logic              req0, req1, lock0, lock1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [3:0]        be0, be1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] bram_addra, bram_addrb;
    logic [DATA_W-1:0] bram_dina;
    logic [3:0]        bram_wea;
    logic [DATA_W-1:0] bram_doutb;

    bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .RSTn(RSTn),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
        .be0(be0), .be1(be1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
    );

    // Block_RAM stand-in: byte-write port a, 1-cycle read port b
    logic [DATA_W-1:0] bram_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ref_mem  [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            bram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        bram_doutb = '0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bram_wea[b]) bram_mem[bram_addra][8*b +: 8] <= bram_dina[8*b +: 8];
        bram_doutb <= bram_mem[bram_addrb];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-port beat queues; the driver holds the head beat until it is granted
    typedef struct packed {
        logic              we;
        logic              lock;
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    logic  took0 = 1'b0;
    logic  took1 = 1'b0;

    always @(posedge clk) begin
        #1;
        if (took0 && q0.size() > 0) q0.delete(0);
        if (took1 && q1.size() > 0) q1.delete(0);
        if (q0.size() > 0) begin
            req0 = 1'b1; we0 = q0[0].we; lock0 = q0[0].lock;
            addr0 = q0[0].addr; be0 = q0[0].be; wdata0 = q0[0].wdata;
        end else begin
            req0 = 1'b0; we0 = 1'b0; lock0 = 1'b0;
        end
        if (q1.size() > 0) begin
            req1 = 1'b1; we1 = q1[0].we; lock1 = q1[0].lock;
            addr1 = q1[0].addr; be1 = q1[0].be; wdata1 = q1[0].wdata;
        end else begin
            req1 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
        end
    end

    // Reference model: who owns the RAM, how many locked beats they have had,
    // who released last, what the BRAM lines should show, and what read data
    // is due next cycle.
    int                m_owner = -1;
    int                m_held  = 0;
    logic              m_last  = 1'b1;
    logic [ADDR_W-1:0] m_ha = '0, m_hb = '0;
    logic [DATA_W-1:0] m_hd = '0, m_rd = '0;
    logic              m_rv0 = 1'b0, m_rv1 = 1'b0;

    always @(negedge clk) begin
        logic              e_g0, e_g1, p_we, p_lock, p_req;
        logic [ADDR_W-1:0] p_addr, e_a, e_b;
        logic [DATA_W-1:0] p_wd, e_d;
        logic [3:0]        p_be, e_w;
        int                p, o;
        took0 = gnt0;
        took1 = gnt1;
        if (!RSTn) begin
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_wea", bram_wea, 0);
            chk("rst_rvalid0", rvalid0, 0);
            chk("rst_rvalid1", rvalid1, 0);
            m_owner = -1; m_held = 0; m_last = 1'b1;
            m_ha = '0; m_hb = '0; m_hd = '0; m_rv0 = 1'b0; m_rv1 = 1'b0;
        end else begin
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (m_owner < 0) begin
                if (req0 && req1) begin
`ifdef BRAM_ARB_RR_EN
                    if (m_last == 1'b1) e_g0 = 1'b1; else e_g1 = 1'b1;
`else
                    e_g0 = 1'b1;
`endif
                end else if (req0) e_g0 = 1'b1;
                else if (req1) e_g1 = 1'b1;
            end else if (m_owner == 0) e_g0 = req0;
            else e_g1 = req1;

            chk("gnt0", gnt0, e_g0);
            chk("gnt1", gnt1, e_g1);
            chk("rvalid0", rvalid0, m_rv0);
            chk("rvalid1", rvalid1, m_rv1);
            if (m_rv0) chk("rdata0", rdata0, m_rd);
            if (m_rv1) chk("rdata1", rdata1, m_rd);

            e_w = 4'b0; e_a = m_ha; e_d = m_hd; e_b = m_hb;
            p_we = 1'b0; p_lock = 1'b0;
            p = e_g1 ? 1 : 0;
            if (e_g0 || e_g1) begin
                p_we   = p ? we1 : we0;
                p_lock = p ? lock1 : lock0;
                p_addr = p ? addr1 : addr0;
                p_be   = p ? be1 : be0;
                p_wd   = p ? wdata1 : wdata0;
                if (p_we) begin
                    e_w = p_be; e_a = p_addr; e_d = p_wd;
                    m_ha = p_addr; m_hd = p_wd;
                    for (int b = 0; b < 4; b++)
                        if (p_be[b]) ref_mem[p_addr][8*b +: 8] = p_wd[8*b +: 8];
                end else begin
                    e_b = p_addr; m_hb = p_addr;
                    m_rd = ref_mem[p_addr];
                end
            end
            chk("wea", bram_wea, e_w);
            chk("addra", bram_addra, e_a);
            chk("dina", bram_dina, e_d);
            chk("addrb", bram_addrb, e_b);
            m_rv0 = e_g0 & ~we0;
            m_rv1 = e_g1 & ~we1;

            if (e_g0 || e_g1) begin
                if (p_lock && (m_held + 1 < BURST_MAX)) begin
                    m_owner = p; m_held++;
                end else begin
                    m_owner = -1; m_held = 0; m_last = p[0];
                end
            end else if (m_owner >= 0) begin
                o = m_owner;
                p_req = o ? req1 : req0;
                if (!p_req && !(o ? lock1 : lock0)) begin
                    m_owner = -1; m_held = 0; m_last = o[0];
                end
            end
        end
    end

    task automatic wait_gnt(input int port, input string name);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port == 0 && gnt0) || (port == 1 && gnt1)) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: no grant on port %0d within 20 cycles", name, port);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 RSTn = 1'b0;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #3 RSTn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] seq8;
    logic [6:0] s1, s0;

    initial begin
        RSTn = 1'b1;
        req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; be0 = '0; be1 = '0; wdata0 = '0; wdata1 = '0;
        #2 RSTn = 1'b0;
        @(negedge clk);
        chk("reset_rvalid0", rvalid0, 0);
        chk("reset_wea", bram_wea, 0);
        @(posedge clk);
        #3 RSTn = 1'b1;

        // 1: write then read back
        q0.push_back('{1'b1, 1'b0, 14'h010, 4'hF, 32'hDEADBEEF});
        wait_gnt(0, "t1_wr");
        chk("t1_wea", bram_wea, 4'hF);
        chk("t1_addra", bram_addra, 14'h010);
        chk("t1_dina", bram_dina, 32'hDEADBEEF);
        q0.push_back('{1'b0, 1'b0, 14'h010, 4'h0, 32'h0});
        wait_gnt(0, "t1_rd");
        @(negedge clk);
        chk("t1_rvalid0", rvalid0, 1);
        chk("t1_rdata0", rdata0, 32'hDEADBEEF);
        idle(2);

        // 4: read at top address with be=0
        q0.push_back('{1'b0, 1'b0, 14'h3FFF, 4'h0, 32'h0});
        wait_gnt(0, "t4_rd");
        chk("t4_addrb", bram_addrb, 14'h3FFF);
        chk("t4_wea", bram_wea, 4'h0);
        @(negedge clk);
        chk("t4_rvalid0", rvalid0, 1);
        chk("t4_rvalid1", rvalid1, 0);
        idle(2);

        // 2: contention on plain reads right after reset (last=1)
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{1'b0, 1'b0, 14'(16'h100 + i), 4'h0, 32'h0});
            q1.push_back('{1'b0, 1'b0, 14'(16'h200 + i), 4'h0, 32'h0});
        end
        seq8 = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0 && !(gnt0 || gnt1)) @(negedge clk);
            chk("t2_one_gnt", {gnt0, gnt1}, (gnt1 ? 2'b01 : 2'b10));
            seq8 = {seq8[6:0], gnt1};
        end
`ifdef BRAM_ARB_RR_EN
        chk("t2_seq", seq8, 8'b0101_0101);
`else
        chk("t2_seq", seq8, 8'b0000_1111);
`endif
        idle(3);

        // 3: port1 locked burst of 6, port0 waiting from beat 2
        for (int i = 0; i < 6; i++)
            q1.push_back('{1'b0, 1'b1, 14'(16'h300 + i), 4'h0, 32'h0});
        wait_gnt(1, "t3_first");
        q0.push_back('{1'b0, 1'b0, 14'h010, 4'h0, 32'h0});
        s1 = '0; s0 = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            s1 = {s1[5:0], gnt1};
            s0 = {s0[5:0], gnt0};
        end
        chk("t3_gnt1_seq", s1, 7'b1110110);
        chk("t3_gnt0_seq", s0, 7'b0001000);
        idle(3);

        // 6: owner abandons a locked burst, waiting port1 gets the RAM
        q0.push_back('{1'b1, 1'b1, 14'h020, 4'h3, 32'h1234ABCD});
        wait_gnt(0, "t6_wr");
        q1.push_back('{1'b0, 1'b0, 14'h020, 4'h0, 32'h0});
        @(negedge clk);
        chk("t6_hold_gnt1", gnt1, 0);
        @(negedge clk);
        chk("t6_gnt1", gnt1, 1);
        @(negedge clk);
        chk("t6_rdata1", rdata1, 32'h0000ABCD);
        idle(2);

        // 5: reset during beat 2 of a locked port0 burst
        for (int i = 0; i < 3; i++)
            q0.push_back('{1'b0, 1'b1, 14'(16'h400 + i), 4'h0, 32'h0});
        wait_gnt(0, "t5_b1");
        @(posedge clk);
        #3 RSTn = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("t5_gnt0", gnt0, 0);
        chk("t5_rvalid0", rvalid0, 0);
        chk("t5_wea", bram_wea, 0);
        q1.push_back('{1'b0, 1'b0, 14'h010, 4'h0, 32'h0});
        @(posedge clk);
        #3 RSTn = 1'b1;
        @(negedge clk);
        chk("t5_gnt1_first", gnt1, 1);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
